// File: rtl/sdspi_pkg.sv
// sdspi_pkg: register map, status/ctrl bit positions and FSM states shared by the SD SPI master.
package sdspi_pkg;
    localparam logic [3:0] ADDR_DATA   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_CTRL   = 4'd2;
    localparam logic [3:0] ADDR_DIV    = 4'd3;
    localparam int ST_BUSY  = 0;
    localparam int ST_RXV   = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_WERR  = 3;
    localparam int ST_FULL  = 4;
    localparam int CTRL_CS  = 0;
    localparam int CTRL_IE  = 1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_DONE} state_e;
endpackage

// File: rtl/sdspi_if.sv
// sdspi_if: CPU I/O bus slot of the SD SPI master, including its level interrupt.
interface sdspi_if;
    logic [3:0] io_addr;
    logic       io_write;
    logic       io_read;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       interrupt;
    modport master (output io_addr, io_write, io_read, io_wdata, input io_rdata, interrupt);
    modport slave  (input io_addr, io_write, io_read, io_wdata, output io_rdata, interrupt);
endinterface

// File: rtl/sdspi_rxfifo.sv
// sdspi_rxfifo: synchronous FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module sdspi_rxfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
    logic         do_push, do_pop;
    assign empty   = wp_q == rp_q;
    assign full    = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wp_d    = wp_q + (AW+1)'(do_push);
    assign rp_d    = rp_q + (AW+1)'(do_pop);
    assign dout    = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sdspi.sv
// sdspi: SPI mode-0 SD card master on the I/O bus; one byte per DATA write, level rx interrupt.
// Define SDSPI_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry FIFO instead of one register.
module sdspi
    import sdspi_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int DIV_RESET  = 63,
    parameter int FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    sdspi_if.slave io,
    output logic   sd_cs,
    output logic   sd_sck,
    output logic   sd_mosi,
    input  logic   sd_miso
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [7:0]       tx_q, tx_d, rx_sh_q, rx_sh_d, rx_dout, status;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       ctrl_q, ctrl_d, miso_q, miso_d;
    logic             sck_q, sck_d, mosi_q, mosi_d, ovr_q, ovr_d, werr_q, werr_d;
    logic             data_wr, status_wr, ctrl_wr, div_wr, busy, push, pop;
    logic             rx_valid, store_full, fifo_full;

    assign busy      = state_q != S_IDLE;
    assign data_wr   = io.io_write && io.io_addr == ADDR_DATA;
    assign status_wr = io.io_write && io.io_addr == ADDR_STATUS;
    assign ctrl_wr   = io.io_write && io.io_addr == ADDR_CTRL;
    assign div_wr    = io.io_write && io.io_addr == ADDR_DIV;
    assign pop       = io.io_read && io.io_addr == ADDR_DATA && rx_valid;

`ifdef SDSPI_RX_FIFO_EN
    logic rx_empty;
    sdspi_rxfifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rxfifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(rx_sh_q),
        .full(fifo_full), .empty(rx_empty), .dout(rx_dout)
    );
    assign rx_valid   = !rx_empty;
    assign store_full = fifo_full;
`else
    logic [7:0]  rxb_q, rxb_d;
    logic        rxv_q, rxv_d;
    logic [31:0] unused_depth;
    assign unused_depth = 32'(FIFO_DEPTH);
    // A pop in the same cycle frees the register, so the push is accepted.
    assign rxb_d      = push && (!rxv_q || pop) ? rx_sh_q : rxb_q;
    assign rxv_d      = push || (rxv_q && !pop);
    assign rx_dout    = rxb_q;
    assign rx_valid   = rxv_q;
    assign store_full = rxv_q;
    assign fifo_full  = 1'b0;
    always_ff @(posedge clk) begin
        if (reset) begin
            rxb_q <= '0;
            rxv_q <= 1'b0;
        end else begin
            rxb_q <= rxb_d;
            rxv_q <= rxv_d;
        end
    end
`endif

    assign miso_d = {miso_q[0], sd_miso};
    assign ctrl_d = ctrl_wr ? io.io_wdata[1:0] : ctrl_q;
    assign div_d  = div_wr ? DIV_W'(io.io_wdata) : div_q;
    assign ovr_d  = (ovr_q && !(status_wr && io.io_wdata[ST_OVR])) || (push && store_full && !pop);
    assign werr_d = (werr_q && !(status_wr && io.io_wdata[ST_WERR])) || (data_wr && busy);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        bit_d   = bit_q;
        mosi_d  = mosi_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_wr) begin
                    tx_d    = io.io_wdata;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mosi_d  = tx_q[7];
                cnt_d   = div_q;
                bit_d   = '0;
                state_d = S_LOW;
            end
            S_LOW: begin
                cnt_d = cnt_q - DIV_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    rx_sh_d = {rx_sh_q[6:0], miso_q[1]};
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                cnt_d = cnt_q - DIV_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    tx_d    = {tx_q[6:0], 1'b0};
                    mosi_d  = tx_q[6];
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? S_DONE : S_LOW;
                end
            end
            S_DONE: begin
                mosi_d  = 1'b1;
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        sck_d = state_d == S_HIGH;
    end

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_RXV]   = rx_valid;
        status[ST_OVR]   = ovr_q;
        status[ST_WERR]  = werr_q;
        status[ST_FULL]  = fifo_full;
        io.io_rdata = io.io_addr == ADDR_DATA   ? (rx_valid ? rx_dout : 8'hFF) :
                      io.io_addr == ADDR_STATUS ? status :
                      io.io_addr == ADDR_CTRL   ? {6'b0, ctrl_q} :
                      io.io_addr == ADDR_DIV    ? 8'(div_q) : 8'h00;
    end

    assign io.interrupt = ctrl_q[CTRL_IE] && rx_valid;
    assign sd_cs        = !ctrl_q[CTRL_CS];
    assign sd_sck       = sck_q;
    assign sd_mosi      = mosi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= DIV_W'(DIV_RESET);
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            bit_q   <= '0;
            ctrl_q  <= '0;
            miso_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            ovr_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            bit_q   <= bit_d;
            ctrl_q  <= ctrl_d;
            miso_q  <= miso_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ovr_q   <= ovr_d;
            werr_q  <= werr_d;
        end
    end
endmodule

// File: tb/tb_sdspi.sv
// tb_sdspi: directed self-checking bench for the SD SPI master (default build or SDSPI_RX_FIFO_EN).
module tb_sdspi;
    import sdspi_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sd_cs, sd_sck, sd_mosi;
    logic sd_miso = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    sdspi_if bus();
    sdspi dut (
        .clk(clk), .reset(reset), .io(bus),
        .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.io_addr  = a;
        bus.io_wdata = d;
        bus.io_write = 1'b1;
        @(posedge clk);
        #1 bus.io_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.io_addr = a;
        bus.io_read = 1'b1;
        #1 d = bus.io_rdata;
        @(posedge clk);
        #1 bus.io_read = 1'b0;
    endtask

    // SCK rise j lands on edge 1+(div+1)*(2j+1) after the write; the 2-flop miso
    // synchroniser means the bit for that rise must be on the pin 3 edges earlier.
    function automatic int rises_by(input int k, input int div);
        int c = 0;
        for (int j = 0; j < 8; j++)
            if (1 + (div + 1) * (2 * j + 1) <= k + 2) c++;
        return c;
    endfunction

    // inj_kind: 0 none, 1 DATA write at negedge inj_k, 2 DATA read at negedge inj_k
    task automatic xfer(input logic [7:0] tx, input logic [7:0] miso_b, input int div,
                        input int inj_k, input int inj_kind, output logic [7:0] popped);
        int         rises = 0;
        int         done = -1;
        int         j;
        logic       prev = 1'b0;
        logic [7:0] mo = '0;
        popped  = '0;
        sd_miso = miso_b[7];
        wr(ADDR_DATA, tx);
        bus.io_addr = ADDR_STATUS;
        for (int k = 0; k < 2000 && done < 0; k++) begin
            @(negedge clk);
            if (bus.io_write || bus.io_read) begin
                bus.io_write = 1'b0;
                bus.io_read  = 1'b0;
                bus.io_addr  = ADDR_STATUS;
                #1;
            end
            j = rises_by(k, div);
            sd_miso = j < 8 ? miso_b[7-j] : 1'b1;
            if (sd_sck && !prev) begin
                mo = {mo[6:0], sd_mosi};
                rises++;
            end
            prev = sd_sck;
            if (!bus.io_rdata[ST_BUSY]) done = k;
            else if (k == inj_k && inj_kind == 1) begin
                bus.io_addr  = ADDR_DATA;
                bus.io_wdata = ~tx;
                bus.io_write = 1'b1;
            end else if (k == inj_k && inj_kind == 2) begin
                bus.io_addr = ADDR_DATA;
                bus.io_read = 1'b1;
                #1 popped = bus.io_rdata;
            end
        end
        check("xfer_latency", done, 2 + 16 * (div + 1));
        check("xfer_sck_rises", rises, 8);
        check("xfer_mosi", mo, tx);
    endtask

    initial begin
        logic [7:0] d, p;
        int         r;
        logic       prev;
        bus.io_addr  = '0;
        bus.io_write = 1'b0;
        bus.io_read  = 1'b0;
        bus.io_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("rst_cs", sd_cs, 1);
        check("rst_sck", sd_sck, 0);
        check("rst_mosi", sd_mosi, 1);
        check("rst_irq", bus.interrupt, 0);
        rd(ADDR_DIV, d);    check("rst_div", d, 63);
        rd(ADDR_STATUS, d); check("rst_status", d, 8'h00);
        rd(ADDR_CTRL, d);   check("rst_ctrl", d, 8'h00);
        rd(4'd7, d);        check("unmapped_read", d, 8'h00);

        wr(ADDR_DIV, 8'd0);
        wr(ADDR_CTRL, 8'h01);
        check("cs_asserted", sd_cs, 0);
        xfer(8'hA5, 8'h3C, 0, -1, 0, p);
        rd(ADDR_STATUS, d); check("status_rxv", d, 8'h02);
        rd(ADDR_DATA, d);   check("rx_a5", d, 8'h3C);
        rd(ADDR_STATUS, d); check("status_after_pop", d, 8'h00);
        rd(ADDR_DATA, d);   check("empty_read", d, 8'hFF);
        rd(ADDR_STATUS, d); check("empty_read_no_effect", d, 8'h00);

        xfer(8'h5A, 8'hC3, 0, 3, 1, p);
        rd(ADDR_STATUS, d); check("wr_err_set", d, 8'h0A);
        wr(ADDR_STATUS, 8'h08);
        rd(ADDR_STATUS, d); check("wr_err_clear", d, 8'h02);
        rd(ADDR_DATA, d);   check("rx_5a", d, 8'hC3);

        wr(ADDR_CTRL, 8'h03);
        xfer(8'h81, 8'h7E, 0, -1, 0, p);
        check("irq_set", bus.interrupt, 1);
        rd(ADDR_DATA, d);   check("rx_81", d, 8'h7E);
        check("irq_clear", bus.interrupt, 0);
        wr(ADDR_CTRL, 8'h01);

        wr(ADDR_DIV, 8'd2);
        rd(ADDR_DIV, d);    check("div_readback", d, 8'd2);
        xfer(8'hC6, 8'h5B, 2, -1, 0, p);
        rd(ADDR_DATA, d);   check("rx_div2", d, 8'h5B);
        wr(ADDR_DIV, 8'd0);

`ifdef SDSPI_RX_FIFO_EN
        for (int i = 0; i < 4; i++) xfer(8'h10 + 8'(i), 8'hA0 + 8'(i), 0, -1, 0, p);
        rd(ADDR_STATUS, d); check("fifo_full", d, 8'h12);
        xfer(8'h99, 8'hEE, 0, -1, 0, p);
        rd(ADDR_STATUS, d); check("fifo_overrun", d, 8'h16);
        for (int i = 0; i < 4; i++) begin
            rd(ADDR_DATA, d); check("fifo_order", d, 8'hA0 + 8'(i));
        end
        rd(ADDR_STATUS, d); check("fifo_drained", d, 8'h04);
`else
        xfer(8'h11, 8'h22, 0, -1, 0, p);
        xfer(8'h33, 8'h44, 0, -1, 0, p);
        rd(ADDR_STATUS, d); check("overrun_set", d, 8'h06);
        rd(ADDR_DATA, d);   check("overrun_keeps_first", d, 8'h22);
        rd(ADDR_STATUS, d); check("overrun_sticky", d, 8'h04);
`endif
        wr(ADDR_STATUS, 8'h04);
        rd(ADDR_STATUS, d); check("overrun_clear", d, 8'h00);

        xfer(8'h55, 8'h66, 0, -1, 0, p);
        xfer(8'h77, 8'h88, 0, 17, 2, p);
        check("pop_push_popped", p, 8'h66);
        rd(ADDR_STATUS, d); check("pop_push_no_overrun", d, 8'h02);
        rd(ADDR_DATA, d);   check("pop_push_new", d, 8'h88);

        wr(ADDR_DATA, 8'h0F);
        r = 0;
        prev = 1'b0;
        for (int k = 0; k < 200 && r < 4; k++) begin
            @(negedge clk);
            if (sd_sck && !prev) r++;
            prev = sd_sck;
        end
        check("reached_bit4", r, 4);
        check("mid_mosi_low", sd_mosi, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", sd_cs, 1);
        check("abort_sck", sd_sck, 0);
        check("abort_mosi", sd_mosi, 1);
        @(negedge clk) reset = 1'b0;
        rd(ADDR_STATUS, d); check("abort_status", d, 8'h00);
        rd(ADDR_DATA, d);   check("abort_no_byte", d, 8'hFF);
        rd(ADDR_DIV, d);    check("abort_div", d, 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
